riscv_bif_arbiter: RTL



---
 rtl/riscv_bif_arbiter_if.sv | 50 +++++
 rtl/riscv_bif_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/riscv_bif_arbiter_if.sv
// riscv_bif_arbiter_if
//   Bundles the instruction-fetch port (i_*), the data port (d_*) and the shared memory bus (bus_*)
//   seen by riscv_bif_arbiter.
//   modport master : arbiter side (takes i/d requests and bus responses, drives acks and bus requests)
//   modport slave  : environment side (requesters plus memory bus)
interface riscv_bif_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic                  i_ack;
   logic [DATA_W-1:0]     i_rdata;
   logic                  i_err;

   logic                  d_req;
   logic                  d_rnw;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W/8-1:0]   d_wmask;
   logic [DATA_W-1:0]     d_wdata;
   logic                  d_ack;
   logic [DATA_W-1:0]     d_rdata;
   logic                  d_err;

   logic                  bus_req;
   logic                  bus_rnw;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W/8-1:0]   bus_wmask;
   logic [DATA_W-1:0]     bus_wdata;
   logic                  bus_ack;
   logic [DATA_W-1:0]     bus_rdata;

   modport master (
      input  i_req, i_addr,
      output i_ack, i_rdata, i_err,
      input  d_req, d_rnw, d_addr, d_wmask, d_wdata,
      output d_ack, d_rdata, d_err,
      output bus_req, bus_rnw, bus_addr, bus_wmask, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      output i_req, i_addr,
      input  i_ack, i_rdata, i_err,
      output d_req, d_rnw, d_addr, d_wmask, d_wdata,
      input  d_ack, d_rdata, d_err,
      input  bus_req, bus_rnw, bus_addr, bus_wmask, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/riscv_bif_arbiter.sv
// riscv_bif_arbiter
//   Shares one memory bus between the instruction-fetch port (read-only) and the data port
//   (read/write). One grant at a time; bus outputs and acks are combinational from the granted port
//   and the bus response. A granted access that sees no bus_ack for TIMEOUT cycles is aborted with
//   x_ack + x_err (TIMEOUT = 0 disables the abort).
//   Ports: clk, rstn (async, active-low), bif (riscv_bif_arbiter_if.master), arb_busy (granted).
//   Build option: RISCV_BIF_ARB_RR_EN -> contention alternates between ports (last-grant register);
//   undefined -> D always wins contention.
//
//   state   | meaning
//   IDLE    | no grant, bus outputs 0, arbitration happens here
//   GRANT_I | fetch port owns the bus until bus_ack or timeout
//   GRANT_D | data port owns the bus until bus_ack or timeout
module riscv_bif_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rstn,
   riscv_bif_arbiter_if.master bif,
   output logic                arb_busy
);
   localparam int         STRB_W  = DATA_W / 8;
   localparam bit         TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               sel_d;
   logic               to_hit;

   logic               bus_req_c, bus_rnw_c;
   logic [ADDR_W-1:0]  bus_addr_c;
   logic [STRB_W-1:0]  bus_wmask_c;
   logic [DATA_W-1:0]  bus_wdata_c;
   logic               i_ack_c, i_err_c, d_ack_c, d_err_c;
   logic [DATA_W-1:0]  i_rdata_c, d_rdata_c;

`ifdef RISCV_BIF_ARB_RR_EN
   // 1 = last grant went to D; reset to I so the first contention goes to D
   logic last_was_d_q, last_was_d_d;

   assign sel_d = bif.d_req & (~bif.i_req | ~last_was_d_q);

   always_comb begin
      last_was_d_d = last_was_d_q;
      if (state_q == IDLE && (bif.i_req || bif.d_req)) last_was_d_d = sel_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) last_was_d_q <= 1'b0;
      else       last_was_d_q <= last_was_d_d;
   end
`else
   assign sel_d = bif.d_req;
`endif

   // bus_ack on the terminal cycle takes precedence over the abort
   assign to_hit = TO_EN && (cnt_q == TO_LAST) && !bif.bus_ack;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_c   = 1'b0;
      bus_rnw_c   = 1'b0;
      bus_addr_c  = '0;
      bus_wmask_c = '0;
      bus_wdata_c = '0;
      i_ack_c     = 1'b0;
      i_err_c     = 1'b0;
      i_rdata_c   = '0;
      d_ack_c     = 1'b0;
      d_err_c     = 1'b0;
      d_rdata_c   = '0;
      unique case (state_q)
         IDLE: begin
            if (bif.i_req || bif.d_req) begin
               state_d = sel_d ? GRANT_D : GRANT_I;
               cnt_d   = '0;
            end
         end
         GRANT_I: begin
            bus_req_c  = 1'b1;
            bus_rnw_c  = 1'b1;
            bus_addr_c = bif.i_addr;
            if (bif.bus_ack) begin
               i_ack_c   = 1'b1;
               i_rdata_c = bif.bus_rdata;
               state_d   = IDLE;
            end else if (to_hit) begin
               i_ack_c = 1'b1;
               i_err_c = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GRANT_D: begin
            bus_req_c   = 1'b1;
            bus_rnw_c   = bif.d_rnw;
            bus_addr_c  = bif.d_addr;
            bus_wmask_c = bif.d_wmask;
            bus_wdata_c = bif.d_wdata;
            if (bif.bus_ack) begin
               d_ack_c   = 1'b1;
               d_rdata_c = bif.bus_rdata;
               state_d   = IDLE;
            end else if (to_hit) begin
               d_ack_c = 1'b1;
               d_err_c = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bif.bus_req   = bus_req_c;
   assign bif.bus_rnw   = bus_rnw_c;
   assign bif.bus_addr  = bus_addr_c;
   assign bif.bus_wmask = bus_wmask_c;
   assign bif.bus_wdata = bus_wdata_c;
   assign bif.i_ack     = i_ack_c;
   assign bif.i_err     = i_err_c;
   assign bif.i_rdata   = i_rdata_c;
   assign bif.d_ack     = d_ack_c;
   assign bif.d_err     = d_err_c;
   assign bif.d_rdata   = d_rdata_c;
   assign arb_busy      = (state_q != IDLE);
endmodule
